// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty thresholds, sticky error flags and flush.
module param_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEn,
    input  logic                  readEn,
    input  logic                  flush,
    input  logic                  clearErr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_L    = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  empty, full;
    logic                  rd_req_ok, wr_req_ok;
    logic                  rd_ok, wr_ok;

    // Status flags decode from the registered level only, so they never glitch.
    always_comb begin
        empty        = (level_q == '0);
        full         = (level_q == DEPTH_L);
        EMPTY        = empty;
        FULL         = full;
        ALMOST_FULL  = (level_q >= AFULL_L);
        ALMOST_EMPTY = (level_q <= AEMPTY_L);
        level        = level_q;
        dataOut      = data_q;
        OVERFLOW     = ovf_q;
        UNDERFLOW    = udf_q;
    end

    // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
    always_comb begin
        rd_req_ok = readEn & ~empty;
        wr_req_ok = writeEn & (~full | rd_req_ok);
        rd_ok     = rd_req_ok & ~flush;
        wr_ok     = wr_req_ok & ~flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            if (clearErr) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                data_d   = mem_q[rd_ptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + ONE_L;
                2'b01:   level_d = level_q - ONE_L;
                default: level_d = level_q;
            endcase
            // A new error event takes precedence over a concurrent clear.
            if (writeEn & ~wr_req_ok) ovf_d = 1'b1;
            else if (clearErr)        ovf_d = 1'b0;
            if (readEn & ~rd_req_ok)  udf_d = 1'b1;
            else if (clearErr)        udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem_q[wr_ptr_q] <= dataIn;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: queue-based reference model, scoreboard of read data
// checked by an independent monitor, directed scenarios then random traffic.
module tb_param_fifo;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AF_TH  = 12;
    localparam int AE_TH  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          writeEn = 1'b0;
    logic          readEn = 1'b0;
    logic          flush = 1'b0;
    logic          clearErr = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic [DW-1:0] dataOut;
    logic          EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
    logic [AW:0]   level;

    param_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF_TH), .AEMPTY_THRESH(AE_TH)
    ) dut (
        .clk(clk), .reset(reset), .writeEn(writeEn), .readEn(readEn),
        .flush(flush), .clearErr(clearErr), .dataIn(dataIn), .dataOut(dataOut),
        .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY), .level(level),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_fifo[$];
    int m_ovf  = 0;
    int m_udf  = 0;
    int m_dout = 0;
    // Scoreboard of read data awaiting the monitor
    int exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then compare all outputs.
    task automatic step(input bit we, input bit re, input bit fl, input bit ce,
                        input int din, input bit rst);
        bit rd, wr;
        reset    = rst;
        writeEn  = we;
        readEn   = re;
        flush    = fl;
        clearErr = ce;
        dataIn   = din[DW-1:0];
        if (rst) begin
            m_fifo.delete();
            m_ovf = 0; m_udf = 0; m_dout = 0;
        end else if (fl) begin
            m_fifo.delete();
            if (ce) begin m_ovf = 0; m_udf = 0; end
        end else begin
            rd = re && (m_fifo.size() > 0);
            wr = we && (m_fifo.size() < DEPTH || rd);
            if (we && !wr) m_ovf = 1; else if (ce) m_ovf = 0;
            if (re && !rd) m_udf = 1; else if (ce) m_udf = 0;
            if (rd) begin
                m_dout = m_fifo.pop_front();
                exp_q.push_back(m_dout);
            end
            if (wr) m_fifo.push_back(din & 8'hFF);
        end
        @(posedge clk);
        #1;
        check("level",        int'(level),        m_fifo.size());
        check("EMPTY",        int'(EMPTY),        int'(m_fifo.size() == 0));
        check("FULL",         int'(FULL),         int'(m_fifo.size() == DEPTH));
        check("ALMOST_FULL",  int'(ALMOST_FULL),  int'(m_fifo.size() >= AF_TH));
        check("ALMOST_EMPTY", int'(ALMOST_EMPTY), int'(m_fifo.size() <= AE_TH));
        check("OVERFLOW",     int'(OVERFLOW),     m_ovf);
        check("UNDERFLOW",    int'(UNDERFLOW),    m_udf);
        check("dataOut",      int'(dataOut),      m_dout);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: whenever the DUT accepts a read, the next dataOut must match the scoreboard.
    initial begin
        int exp;
        forever begin
            @(posedge clk);
            if (!reset && !flush && readEn && !EMPTY) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_data: got %0h with no read expected at %0t", dataOut, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (int'(dataOut) != exp) begin
                        errors++;
                        $display("FAIL read_data: got %0h expected %0h at %0t", dataOut, exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        // Reset then fill with 0x00..0x0F
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, i, 0);
        // Overflow at full
        step(1, 0, 0, 0, 8'hAA, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 0);
        // Wrap-around
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, $urandom_range(255), 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 8'h20 + i, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0);
        // Simultaneous access at full
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'h40 + i, 0);
        step(1, 1, 0, 0, 8'h55, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 0);
        // Simultaneous access at empty
        step(1, 1, 0, 0, 8'h66, 0);
        step(0, 1, 0, 0, 0, 0);
        // Error clear, then clear racing a fresh underflow
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        idle();
        // Flush with a write pending
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'h70 + i, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 8'h99, 0);
        idle();
        // Refill then reset with a read pending
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h80 + i, 0);
        step(0, 1, 0, 0, 0, 1);
        idle();
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 55, $urandom_range(99) < 50,
                 $urandom_range(199) == 0, $urandom_range(49) == 0,
                 $urandom_range(255), $urandom_range(499) == 0);
        end
        idle();
        idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
